// File: rtl/control_unit_pkg.sv
// Shared definitions for the Mini SRC control sequencer: opcodes, state encoding,
// instruction classes and the one-hot ALU operation bundle.
package control_unit_pkg;

  localparam int unsigned DivMaxCycles = 64;

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpShr  = 5'b00101;
  localparam logic [4:0] OpShra = 5'b00110;
  localparam logic [4:0] OpShl  = 5'b00111;
  localparam logic [4:0] OpRor  = 5'b01000;
  localparam logic [4:0] OpRol  = 5'b01001;
  localparam logic [4:0] OpAnd  = 5'b01010;
  localparam logic [4:0] OpOr   = 5'b01011;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpAndi = 5'b01101;
  localparam logic [4:0] OpOri  = 5'b01110;
  localparam logic [4:0] OpMul  = 5'b01111;
  localparam logic [4:0] OpDiv  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;
  localparam logic [4:0] OpBr   = 5'b10011;
  localparam logic [4:0] OpJr   = 5'b10100;
  localparam logic [4:0] OpJal  = 5'b10101;
  localparam logic [4:0] OpIn   = 5'b10110;
  localparam logic [4:0] OpOut  = 5'b10111;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  // Explicit codes so the debug state port has a stable meaning.
  typedef enum logic [4:0] {
    StRst   = 5'd0,
    StT0    = 5'd1,
    StT1    = 5'd2,
    StT2    = 5'd3,
    StT3    = 5'd4,
    StT4    = 5'd5,
    StT5    = 5'd6,
    StT6    = 5'd7,
    StT7    = 5'd8,
    StDivw  = 5'd9,
    StPause = 5'd10,
    StHalt  = 5'd11
  } state_e;

  typedef enum logic [3:0] {
    ClsAlu,
    ClsImm,
    ClsUnary,
    ClsMul,
    ClsDiv,
    ClsLd,
    ClsLdi,
    ClsSt,
    ClsBr,
    ClsJr,
    ClsJal,
    ClsIn,
    ClsOut,
    ClsNop,
    ClsHalt
  } iclass_e;

  typedef struct packed {
    logic op_and;
    logic op_or;
    logic op_add;
    logic op_sub;
    logic op_mul;
    logic op_div;
    logic op_shr;
    logic op_shl;
    logic op_ror;
    logic op_rol;
    logic op_neg;
    logic op_not;
    logic op_shra;
    logic op_branch;
  } alu_op_t;

endpackage

// File: rtl/control_unit_op_decoder.sv
// Opcode decoder: maps ir[31:27] to an instruction class and the ALU operation used
// by the class's compute step. Unlisted opcodes decode as nop.
module control_unit_op_decoder
  import control_unit_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_e    iclass,
  output alu_op_t    alu_op
);

  always_comb begin
    iclass = ClsNop;
    alu_op = '0;
    case (opcode)
      OpLd:   iclass = ClsLd;
      OpLdi:  iclass = ClsLdi;
      OpSt:   iclass = ClsSt;
      OpAdd:  begin iclass = ClsAlu;   alu_op.op_add  = 1'b1; end
      OpSub:  begin iclass = ClsAlu;   alu_op.op_sub  = 1'b1; end
      OpShr:  begin iclass = ClsAlu;   alu_op.op_shr  = 1'b1; end
      OpShra: begin iclass = ClsAlu;   alu_op.op_shra = 1'b1; end
      OpShl:  begin iclass = ClsAlu;   alu_op.op_shl  = 1'b1; end
      OpRor:  begin iclass = ClsAlu;   alu_op.op_ror  = 1'b1; end
      OpRol:  begin iclass = ClsAlu;   alu_op.op_rol  = 1'b1; end
      OpAnd:  begin iclass = ClsAlu;   alu_op.op_and  = 1'b1; end
      OpOr:   begin iclass = ClsAlu;   alu_op.op_or   = 1'b1; end
      OpAddi: begin iclass = ClsImm;   alu_op.op_add  = 1'b1; end
      OpAndi: begin iclass = ClsImm;   alu_op.op_and  = 1'b1; end
      OpOri:  begin iclass = ClsImm;   alu_op.op_or   = 1'b1; end
      OpMul:  begin iclass = ClsMul;   alu_op.op_mul  = 1'b1; end
      OpDiv:  begin iclass = ClsDiv;   alu_op.op_div  = 1'b1; end
      OpNeg:  begin iclass = ClsUnary; alu_op.op_neg  = 1'b1; end
      OpNot:  begin iclass = ClsUnary; alu_op.op_not  = 1'b1; end
      OpBr:   iclass = ClsBr;
      OpJr:   iclass = ClsJr;
      OpJal:  iclass = ClsJal;
      OpIn:   iclass = ClsIn;
      OpOut:  iclass = ClsOut;
      OpNop:  iclass = ClsNop;
      OpHalt: iclass = ClsHalt;
      default: iclass = ClsNop;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC control sequencer: fetch T0-T2, class-specific execute T3-T7,
// a bounded wait state for the iterative divider, plus PAUSE and HALT.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned DIV_MAX_CYCLES = DivMaxCycles
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con,
  input  logic        div_done,
  input  logic        stop,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        Cout,
  output logic        InPortout,
  output logic        BAout,
  output logic        Rout,
  output logic        PCin,
  output logic        IncPC,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        Rin,
  output logic        OutPortin,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Read,
  output logic        Write,
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic        SHRA,
  output logic        BRANCH,
  output logic        div_rst,
  output logic        run,
  output logic        fault,
  output logic [4:0]  state
);

  localparam int unsigned CntW = (DIV_MAX_CYCLES > 1) ? $clog2(DIV_MAX_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV_MAX_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fault_q, fault_d;
  iclass_e         iclass;
  alu_op_t         dec_alu, alu_sel;
  state_e          end_st;
  logic            unused_ir;

  assign unused_ir = ^ir[26:0];

  control_unit_op_decoder u_op_decoder (
    .opcode (ir[31:27]),
    .iclass (iclass),
    .alu_op (dec_alu)
  );

  // Instruction boundary: stop is only honoured here.
  assign end_st = stop ? StPause : StT0;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StRst;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fault_d   = fault_q;
    alu_sel   = '0;
    PCout     = 1'b0;
    MDRout    = 1'b0;
    Zhighout  = 1'b0;
    Zlowout   = 1'b0;
    Cout      = 1'b0;
    InPortout = 1'b0;
    BAout     = 1'b0;
    Rout      = 1'b0;
    PCin      = 1'b0;
    IncPC     = 1'b0;
    IRin      = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    Rin       = 1'b0;
    OutPortin = 1'b0;
    CONin     = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Read      = 1'b0;
    Write     = 1'b0;
    div_rst   = 1'b0;

    unique case (state_q)
      StRst: state_d = StT0;
      StT0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
        state_d = StT1;
      end
      StT1: begin
        Read = 1'b1; MDRin = 1'b1;
        state_d = StT2;
      end
      StT2: begin
        MDRout = 1'b1; IRin = 1'b1;
        if (iclass == ClsHalt)     state_d = StHalt;
        else if (iclass == ClsNop) state_d = end_st;
        else                       state_d = StT3;
      end
      StT3: begin
        state_d = StT4;
        unique case (iclass)
          ClsAlu, ClsImm: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          ClsUnary: begin Grb = 1'b1; Rout = 1'b1; alu_sel = dec_alu; Zin = 1'b1; end
          ClsMul: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          ClsDiv: begin
            Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; div_rst = 1'b1;
            cnt_d   = '0;
            state_d = StDivw;
          end
          ClsLd, ClsLdi, ClsSt: begin Grb = 1'b1; Rout = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          ClsBr: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          ClsJr: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; state_d = end_st; end
          ClsJal: begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
          ClsIn: begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; state_d = end_st; end
          ClsOut: begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; state_d = end_st; end
          default: state_d = StT0;
        endcase
      end
      StT4: begin
        state_d = StT5;
        unique case (iclass)
          ClsAlu: begin Grc = 1'b1; Rout = 1'b1; alu_sel = dec_alu; Zin = 1'b1; end
          ClsImm: begin Cout = 1'b1; alu_sel = dec_alu; Zin = 1'b1; end
          ClsUnary: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; state_d = end_st; end
          ClsMul: begin Grb = 1'b1; Rout = 1'b1; alu_sel = dec_alu; Zin = 1'b1; end
          ClsLd, ClsLdi, ClsSt: begin Cout = 1'b1; alu_sel.op_add = 1'b1; Zin = 1'b1; end
          ClsBr: begin PCout = 1'b1; Yin = 1'b1; end
          ClsJal: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; state_d = end_st; end
          default: state_d = StT0;
        endcase
      end
      StT5: begin
        state_d = StT6;
        unique case (iclass)
          ClsAlu, ClsImm, ClsLdi: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            state_d = end_st;
          end
          ClsMul, ClsDiv: begin Zlowout = 1'b1; LOin = 1'b1; end
          ClsLd, ClsSt: begin Zlowout = 1'b1; MARin = 1'b1; end
          ClsBr: begin Cout = 1'b1; alu_sel.op_add = 1'b1; alu_sel.op_branch = 1'b1; Zin = 1'b1; end
          default: state_d = StT0;
        endcase
      end
      StT6: begin
        state_d = end_st;
        unique case (iclass)
          ClsMul, ClsDiv: begin Zhighout = 1'b1; HIin = 1'b1; end
          ClsLd: begin Read = 1'b1; MDRin = 1'b1; state_d = StT7; end
          ClsSt: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_d = StT7; end
          ClsBr: begin
            Zlowout = con;
            PCin    = con;
          end
          default: state_d = StT0;
        endcase
      end
      StT7: begin
        state_d = end_st;
        unique case (iclass)
          ClsLd: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsSt: Write = 1'b1;
          default: state_d = StT0;
        endcase
      end
      StDivw: begin
        Grb = 1'b1; Rout = 1'b1; alu_sel = dec_alu;
        if (div_done) begin
          Zin     = 1'b1;
          state_d = StT5;
        end else if (cnt_q == CntLast) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPause: if (!stop) state_d = StT0;
      StHalt:  state_d = StHalt;
      default: state_d = StRst;
    endcase
  end

  assign AND    = alu_sel.op_and;
  assign OR     = alu_sel.op_or;
  assign ADD    = alu_sel.op_add;
  assign SUB    = alu_sel.op_sub;
  assign MUL    = alu_sel.op_mul;
  assign DIV    = alu_sel.op_div;
  assign SHR    = alu_sel.op_shr;
  assign SHL    = alu_sel.op_shl;
  assign ROR    = alu_sel.op_ror;
  assign ROL    = alu_sel.op_rol;
  assign NEG    = alu_sel.op_neg;
  assign NOT    = alu_sel.op_not;
  assign SHRA   = alu_sel.op_shra;
  assign BRANCH = alu_sel.op_branch;

  assign run   = (state_q inside {StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StDivw});
  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle strobe/state expectations are queued
// as stimulus is applied and checked mid-cycle.
module tb_control_unit;

  logic clk, clr, con, div_done, stop;
  logic [31:0] ir;
  logic PCout, MDRout, Zhighout, Zlowout, Cout, InPortout, BAout, Rout;
  logic PCin, IncPC, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, OutPortin, CONin;
  logic Gra, Grb, Grc, Read, Write;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, SHRA, BRANCH;
  logic div_rst, run, fault;
  logic [4:0] state;

  control_unit #(.DIV_MAX_CYCLES(64)) dut (
    .clk(clk), .clr(clr), .ir(ir), .con(con), .div_done(div_done), .stop(stop),
    .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout), .Cout(Cout),
    .InPortout(InPortout), .BAout(BAout), .Rout(Rout),
    .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
    .Zin(Zin), .HIin(HIin), .LOin(LOin), .Rin(Rin), .OutPortin(OutPortin), .CONin(CONin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .Write(Write),
    .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL),
    .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT), .SHRA(SHRA), .BRANCH(BRANCH),
    .div_rst(div_rst), .run(run), .fault(fault), .state(state)
  );

  logic [41:0] obs;
  assign obs = {PCout, MDRout, Zhighout, Zlowout, Cout, InPortout, BAout, Rout,
                PCin, IncPC, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, OutPortin, CONin,
                Gra, Grb, Grc, Read, Write,
                AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, SHRA, BRANCH,
                div_rst, run, fault};

  localparam logic [41:0] One = 42'd1;
  localparam logic [41:0] PCOUT = One << 41, MDROUT = One << 40, ZHIOUT = One << 39;
  localparam logic [41:0] ZLOOUT = One << 38, COUT = One << 37, INPOUT = One << 36;
  localparam logic [41:0] BAOUT = One << 35, ROUT = One << 34, PCIN = One << 33;
  localparam logic [41:0] INCPC = One << 32, IRIN = One << 31, MARIN = One << 30;
  localparam logic [41:0] MDRIN = One << 29, YIN = One << 28, ZIN = One << 27;
  localparam logic [41:0] HIIN = One << 26, LOIN = One << 25, RIN = One << 24;
  localparam logic [41:0] OUTPIN = One << 23, CONIN = One << 22, GRA = One << 21;
  localparam logic [41:0] GRB = One << 20, GRC = One << 19, READ = One << 18;
  localparam logic [41:0] WRITE = One << 17, A_AND = One << 16, A_ADD = One << 14;
  localparam logic [41:0] A_MUL = One << 12, A_DIV = One << 11, A_NEG = One << 6;
  localparam logic [41:0] A_BR = One << 3, DIVRST = One << 2, R = One << 1, FLT = One;
  localparam logic [41:0] NONE = 42'd0;

  localparam logic [4:0] SRst = 5'd0, ST0 = 5'd1, ST1 = 5'd2, ST2 = 5'd3, ST3 = 5'd4;
  localparam logic [4:0] ST4 = 5'd5, ST5 = 5'd6, ST6 = 5'd7, ST7 = 5'd8;
  localparam logic [4:0] SDivw = 5'd9, SPause = 5'd10, SHalt = 5'd11;

  localparam logic [4:0] OP_LD = 5'b00000, OP_ADD = 5'b00011, OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_MUL = 5'b01111, OP_DIV = 5'b10000, OP_NEG = 5'b10001;
  localparam logic [4:0] OP_BR = 5'b10011, OP_JR = 5'b10100, OP_JAL = 5'b10101;
  localparam logic [4:0] OP_IN = 5'b10110, OP_OUT = 5'b10111, OP_NOP = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011, OP_UNDEF = 5'b11111;

  int n_chk = 0;
  int n_pass = 0;
  string tag_q[$];
  logic [46:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] op);
    return {op, 27'h0a5_3c21};
  endfunction

  // Queue the expectation for the current cycle, check it mid-cycle, advance one cycle.
  task automatic cyc(input string tag, input logic [41:0] v, input logic [4:0] st);
    string t;
    logic [46:0] e;
    tag_q.push_back(tag);
    exp_q.push_back({st, v});
    @(negedge clk);
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    n_chk++;
    assert ({state, obs} === e) n_pass++;
    else $error("FAIL %s: got state=%0d strobes=%h, expected state=%0d strobes=%h",
                t, state, obs, e[46:42], e[41:0]);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string p);
    cyc({p, ".T0"}, R | PCOUT | MARIN | INCPC, ST0);
    cyc({p, ".T1"}, R | READ | MDRIN, ST1);
    cyc({p, ".T2"}, R | MDROUT | IRIN, ST2);
  endtask

  initial begin
    clr = 1'b0; ir = '0; con = 1'b0; div_done = 1'b0; stop = 1'b0;
    @(posedge clk); #1;
    cyc("reset", NONE, SRst);
    cyc("reset_hold", NONE, SRst);
    clr = 1'b1;
    cyc("reset_release", NONE, SRst);

    ir = mk(OP_ADD);
    fetch("add");
    cyc("add.T3", R | GRB | ROUT | YIN, ST3);
    cyc("add.T4", R | GRC | ROUT | A_ADD | ZIN, ST4);
    cyc("add.T5", R | ZLOOUT | GRA | RIN, ST5);

    ir = mk(OP_LD);
    fetch("ld");
    cyc("ld.T3", R | GRB | ROUT | BAOUT | YIN, ST3);
    cyc("ld.T4", R | COUT | A_ADD | ZIN, ST4);
    cyc("ld.T5", R | ZLOOUT | MARIN, ST5);
    cyc("ld.T6", R | READ | MDRIN, ST6);
    cyc("ld.T7", R | MDROUT | GRA | RIN, ST7);

    ir = mk(OP_BR);
    fetch("br0");
    cyc("br0.T3", R | GRA | ROUT | CONIN, ST3);
    cyc("br0.T4", R | PCOUT | YIN, ST4);
    cyc("br0.T5", R | COUT | A_ADD | A_BR | ZIN, ST5);
    cyc("br0.T6", R, ST6);
    fetch("br1");
    cyc("br1.T3", R | GRA | ROUT | CONIN, ST3);
    cyc("br1.T4", R | PCOUT | YIN, ST4);
    cyc("br1.T5", R | COUT | A_ADD | A_BR | ZIN, ST5);
    con = 1'b1;
    cyc("br1.T6", R | ZLOOUT | PCIN, ST6);
    con = 1'b0;

    ir = mk(OP_ANDI);
    fetch("andi");
    cyc("andi.T3", R | GRB | ROUT | YIN, ST3);
    cyc("andi.T4", R | COUT | A_AND | ZIN, ST4);
    cyc("andi.T5", R | ZLOOUT | GRA | RIN, ST5);

    ir = mk(OP_NEG);
    fetch("neg");
    cyc("neg.T3", R | GRB | ROUT | A_NEG | ZIN, ST3);
    cyc("neg.T4", R | ZLOOUT | GRA | RIN, ST4);

    ir = mk(OP_JAL);
    fetch("jal");
    cyc("jal.T3", R | PCOUT | GRB | RIN, ST3);
    cyc("jal.T4", R | GRA | ROUT | PCIN, ST4);

    ir = mk(OP_NOP);
    fetch("nop");
    ir = mk(OP_UNDEF);
    fetch("undef");

    ir = mk(OP_DIV);
    fetch("div");
    cyc("div.T3", R | GRA | ROUT | YIN | DIVRST, ST3);
    for (int i = 0; i < 32; i++) cyc("div.wait", R | GRB | ROUT | A_DIV, SDivw);
    div_done = 1'b1;
    cyc("div.done", R | GRB | ROUT | A_DIV | ZIN, SDivw);
    div_done = 1'b0;
    cyc("div.T5", R | ZLOOUT | LOIN, ST5);
    cyc("div.T6", R | ZHIOUT | HIIN, ST6);

    fetch("div1");
    cyc("div1.T3", R | GRA | ROUT | YIN | DIVRST, ST3);
    div_done = 1'b1;
    cyc("div1.done", R | GRB | ROUT | A_DIV | ZIN, SDivw);
    div_done = 1'b0;
    cyc("div1.T5", R | ZLOOUT | LOIN, ST5);
    cyc("div1.T6", R | ZHIOUT | HIIN, ST6);

    ir = mk(OP_MUL);
    fetch("mul");
    cyc("mul.T3", R | GRA | ROUT | YIN, ST3);
    stop = 1'b1;
    cyc("mul.T4", R | GRB | ROUT | A_MUL | ZIN, ST4);
    cyc("mul.T5", R | ZLOOUT | LOIN, ST5);
    cyc("mul.T6", R | ZHIOUT | HIIN, ST6);
    cyc("pause0", NONE, SPause);
    cyc("pause1", NONE, SPause);
    stop = 1'b0;
    cyc("pause_exit", NONE, SPause);

    ir = mk(OP_IN);
    fetch("in");
    cyc("in.T3", R | INPOUT | GRA | RIN, ST3);
    ir = mk(OP_OUT);
    fetch("out");
    cyc("out.T3", R | GRA | ROUT | OUTPIN, ST3);

    ir = mk(OP_HALT);
    stop = 1'b1;
    fetch("halt");
    for (int i = 0; i < 3; i++) cyc("halt.hold", NONE, SHalt);
    stop = 1'b0;
    cyc("halt.hold_nostop", NONE, SHalt);
    clr = 1'b0;
    cyc("halt.clr", NONE, SRst);
    clr = 1'b1;
    cyc("halt.release", NONE, SRst);

    ir = mk(OP_DIV);
    fetch("divto");
    cyc("divto.T3", R | GRA | ROUT | YIN | DIVRST, ST3);
    for (int i = 0; i < 64; i++) cyc("divto.wait", R | GRB | ROUT | A_DIV, SDivw);
    cyc("divto.halt", FLT, SHalt);
    cyc("divto.sticky", FLT, SHalt);
    clr = 1'b0;
    cyc("divto.clr", NONE, SRst);
    clr = 1'b1;
    cyc("divto.release", NONE, SRst);

    ir = mk(OP_ADD);
    fetch("abort");
    cyc("abort.T3", R | GRB | ROUT | YIN, ST3);
    clr = 1'b0;
    cyc("abort.clr", NONE, SRst);
    clr = 1'b1;
    cyc("abort.release", NONE, SRst);

    ir = mk(OP_JR);
    fetch("jr");
    cyc("jr.T3", R | GRA | ROUT | PCIN, ST3);
    cyc("next.T0", R | PCOUT | MARIN | INCPC, ST0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Mini SRC control sequencer that drives every control input of the register-transfer datapath: bus select, register load, ALU op, memory, port and branch strobes. A state machine runs fetch (T0–T2), then an opcode-specific execute sequence (T3–T7), with a variable-length wait state for the iterative divider. It sits beside the datapath and closes the loop through the IR contents, the CON flip-flop result and the divider done flag.

## Interface
Parameters:
- DIV_MAX_CYCLES, 64, divider wait limit; exceeding it halts with `fault`

Ports:
- clk  in  1  rising-edge clock shared with datapath
- clr  in  1  asynchronous, active-low reset
- ir  in  32  IR contents; opcode = ir[31:27]
- con  in  1  CON flip-flop output (branch condition)
- div_done  in  1  divider result valid
- stop  in  1  pause request, sampled only at instruction boundary
- PCout, MDRout, Zhighout, Zlowout, Cout, InPortout, BAout, Rout  out  1 each  bus-source strobes
- PCin, IncPC, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, OutPortin, CONin  out  1 each  load strobes
- Gra, Grb, Grc  out  1 each  register-field select
- Read, Write  out  1 each  RAM strobes
- AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, SHRA, BRANCH  out  1 each  one-hot ALU op
- div_rst  out  1  divider start/reset pulse
- run  out  1  1 while executing; 0 in HALT/PAUSE/reset
- fault  out  1  sticky divider-timeout flag
- state  out  5  current state encoding, debug only

## Operation
- Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, shr 00101, shra 00110, shl 00111, ror 01000, rol 01001, and 01010, or 01011, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, neg 10001, not 10010, br 10011, jr 10100, jal 10101, in 10110, out 10111, nop 11010, halt 11011; every other code executes as nop.
- Fetch: T0 PCout MARin IncPC; T1 Read MDRin; T2 MDRout IRin.
- R-type ALU: T3 Grb Rout Yin; T4 Grc Rout op Zin; T5 Zlowout Gra Rin.
- addi/andi/ori: T3 Grb Rout Yin; T4 Cout op Zin; T5 Zlowout Gra Rin.
- neg/not: T3 Grb Rout op Zin; T4 Zlowout Gra Rin.
- mul: T3 Gra Rout Yin; T4 Grb Rout MUL Zin; T5 Zlowout LOin; T6 Zhighout HIin.
- div: T3 Gra Rout Yin div_rst; DIVW Grb Rout DIV, Zin asserted only in the cycle div_done=1; then T5/T6 as for mul.
- ld/ldi/st address: T3 Grb Rout BAout Yin; T4 Cout ADD Zin. ldi: T5 Zlowout Gra Rin. ld: T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin. st: T5 Zlowout MARin; T6 Gra Rout MDRin (Read=0); T7 Write.
- br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ADD BRANCH Zin; T6 Zlowout PCin only if con=1, otherwise no strobes.
- jr: T3 Gra Rout PCin. jal (assembler places 15 in rB): T3 PCout Grb Rin; T4 Gra Rout PCin.
- in: T3 InPortout Gra Rin. out: T3 Gra Rout OutPortin. nop: return to T0 after T2.
- halt: enter HALT, all strobes 0, run=0; only clr exits.
- States: RST, T0–T7, DIVW, PAUSE, HALT. Last execute step goes to T0, or to PAUSE if stop=1; PAUSE returns to T0 when stop=0.
- DIVW counter: if DIV_MAX_CYCLES cycles elapse without div_done, set fault and enter HALT.

## Timing
- clr low: state=RST, every output 0, fault cleared; takes effect mid-instruction immediately. First edge after release goes RST→T0.
- Outputs are combinational from state, ir[31:27] and con/div_done; one-hot ALU op; at most one bus-source strobe per cycle.
- Cycles per instruction, fetch included: R-type/imm 6, neg/not 5, mul 7, div 6+N (N = DIVW cycles, ≥1), ld 8, ldi 6, st 8, br 7, jr/in/out 4, jal 5, nop 3.
- div_done high in the first DIVW cycle: N=1. stop is ignored mid-instruction. halt takes priority over stop.

## Structure
- Shared package: opcode constants, state encoding, DIV_MAX_CYCLES default.
- Sub-module op_decoder: opcode → instruction class plus one-hot ALU op. The sequencer switches on class.

## Test plan
- Reset, then add with R2=5, R3=7 into R1: strobes match T0–T5 exactly; R1=12 after 6 cycles; run=1.
- ld R1, 0x10(R0) with mem[0x10]=0xDEADBEEF: BAout in T3, Read in T1 and T6; R1=0xDEADBEEF at cycle 8.
- br with con=0 and then con=1 (C=4, PC=8): PCin absent vs present in T6; final PC 9 vs 13.
- div 100/7 with div_done after 33 cycles: LO=14, HI=2; Zin only in done cycle. div_done held low for 64 cycles: fault=1, HALT.
- halt then clr pulse mid-HALT: run=0, all strobes 0; after release fetch resumes at T0.
- stop raised during mul T4: instruction completes (HI/LO written), PAUSE entered; stop low → T0 next edge.
